// File: rtl/decapsulation_if.sv
// ---------------------------------------------------------------------------
// decapsulation_if
// Purpose : groups the five external memory write ports of the
//           decapsulation core (ciphertext, secret key, confirmation,
//           rejection value and the r-memory preload port).
// Ports   : wr_en_X / wr_addr_X / wr_di_X for X in {C, sk, k, rho, r}.
//           The byte memories use Q_DEPTH_K-bit addresses and P_WIDTH_K-bit data;
//           the r memory uses Q_DEPTH-bit addresses and P_WIDTH-bit data.
// Modports: master drives the writes, slave (the core) receives them.
// ---------------------------------------------------------------------------
interface decapsulation_if #(
    parameter int Q_DEPTH_K = 11,
    parameter int P_WIDTH_K = 8,
    parameter int Q_DEPTH   = 10,
    parameter int P_WIDTH   = 16
);
    logic                 wr_en_C;
    logic [Q_DEPTH_K-1:0] wr_addr_C;
    logic [P_WIDTH_K-1:0] wr_di_C;
    logic                 wr_en_sk;
    logic [Q_DEPTH_K-1:0] wr_addr_sk;
    logic [P_WIDTH_K-1:0] wr_di_sk;
    logic                 wr_en_k;
    logic [Q_DEPTH_K-1:0] wr_addr_k;
    logic [P_WIDTH_K-1:0] wr_di_k;
    logic                 wr_en_rho;
    logic [Q_DEPTH_K-1:0] wr_addr_rho;
    logic [P_WIDTH_K-1:0] wr_di_rho;
    logic                 wr_en_r;
    logic [Q_DEPTH-1:0]   wr_addr_r;
    logic [P_WIDTH-1:0]   wr_di_r;

    modport master (
        output wr_en_C, wr_addr_C, wr_di_C,
        output wr_en_sk, wr_addr_sk, wr_di_sk,
        output wr_en_k, wr_addr_k, wr_di_k,
        output wr_en_rho, wr_addr_rho, wr_di_rho,
        output wr_en_r, wr_addr_r, wr_di_r
    );

    modport slave (
        input wr_en_C, wr_addr_C, wr_di_C,
        input wr_en_sk, wr_addr_sk, wr_di_sk,
        input wr_en_k, wr_addr_k, wr_di_k,
        input wr_en_rho, wr_addr_rho, wr_di_rho,
        input wr_en_r, wr_addr_r, wr_di_r
    );
endinterface

// File: rtl/decapsulation.sv
// ---------------------------------------------------------------------------
// decapsulation
// Purpose : streams N byte triples out of the ciphertext / secret-key /
//           confirmation / rejection memories, writes e = C ^ sk into the
//           r memory and folds e, k and rho into three sets of eight 32-bit
//           rotate-xor lanes. On completion the r digest and the session
//           digest (k lanes, or rho lanes if any e differed from k) are
//           latched and Valid is raised.
// Ports   : Clk        rising-edge clock
//           Reset      synchronous, active-low reset
//           Cmd        0 no-op, 1 clear, 2 no-op, 3 start
//           wr         external memory write ports (decapsulation_if.slave)
//           out_addr   lane select for out_r / out_k
//           out_r      r-digest lane out_addr
//           out_k      session-digest lane out_addr
//           Valid      result ready
// ---------------------------------------------------------------------------
module decapsulation #(
    parameter int N         = 761,
    parameter int Q_DEPTH_K = 11,
    parameter int P_WIDTH_K = 8,
    parameter int Q_DEPTH   = 10,
    parameter int P_WIDTH   = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [1:0]           Cmd,
    decapsulation_if.slave       wr,
    input  logic [2:0]           out_addr,
    output logic [31:0]          out_r,
    output logic [31:0]          out_k,
    output logic                 Valid
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [Q_DEPTH_K-1:0] N_IDX    = Q_DEPTH_K'(N);
    localparam logic [Q_DEPTH_K-1:0] LAST_IDX = Q_DEPTH_K'(N - 1);

    function automatic logic [31:0] rotl5(input logic [31:0] x);
        rotl5 = {x[26:0], x[31:27]};
    endfunction

    logic [P_WIDTH_K-1:0] mem_C   [0:(2**Q_DEPTH_K)-1];
    logic [P_WIDTH_K-1:0] mem_sk  [0:(2**Q_DEPTH_K)-1];
    logic [P_WIDTH_K-1:0] mem_k   [0:(2**Q_DEPTH_K)-1];
    logic [P_WIDTH_K-1:0] mem_rho [0:(2**Q_DEPTH_K)-1];
    logic [P_WIDTH-1:0]   mem_r   [0:(2**Q_DEPTH)-1];

    state_t               state_q, state_d;
    logic [Q_DEPTH_K-1:0] rd_idx_q, rd_idx_d;
    logic                 p1_vld_q;
    logic [Q_DEPTH_K-1:0] p1_idx_q;
    logic                 fin_q;
    logic [P_WIDTH_K-1:0] c_rd_q, sk_rd_q, k_rd_q, rho_rd_q;
    logic [31:0]          lane_r_q [0:7];
    logic [31:0]          lane_k_q [0:7];
    logic [31:0]          lane_p_q [0:7];
    logic [31:0]          o_r_q    [0:7];
    logic [31:0]          o_k_q    [0:7];
    logic                 mism_q;
    logic                 valid_q;

    logic                 start_s, clear_s, ext_wr_ok_s, issue_s, finish_s;
    logic [P_WIDTH_K-1:0] e_s;
    logic [2:0]           lane_sel_s;

    assign e_s        = c_rd_q ^ sk_rd_q;
    assign lane_sel_s = p1_idx_q[2:0];

    // FSM state register
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_s) state_d = BUSY;
                else         state_d = IDLE;
            end
            BUSY: begin
                if (finish_s) state_d = DONE;
                else          state_d = BUSY;
            end
            DONE: begin
                if (start_s)      state_d = BUSY;
                else if (clear_s) state_d = IDLE;
                else              state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM output decode: commands and external writes only act outside BUSY
    always_comb begin
        start_s     = 1'b0;
        clear_s     = 1'b0;
        ext_wr_ok_s = 1'b0;
        issue_s     = 1'b0;
        finish_s    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                ext_wr_ok_s = 1'b1;
                start_s     = (Cmd == 2'd3);
                clear_s     = (Cmd == 2'd1);
            end
            BUSY: begin
                issue_s  = (rd_idx_q < N_IDX);
                finish_s = fin_q;
            end
            default: ext_wr_ok_s = 1'b0;
        endcase
    end

    // Read-index next value: reloads on start, advances while issuing
    always_comb begin
        rd_idx_d = rd_idx_q;
        if (start_s) begin
            rd_idx_d = {Q_DEPTH_K{1'b0}};
        end else if (issue_s) begin
            rd_idx_d = rd_idx_q + Q_DEPTH_K'(1);
        end else begin
            rd_idx_d = rd_idx_q;
        end
    end

    // Read index and pipeline tracking; fin_q fires the cycle after the last lane update
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            rd_idx_q <= {Q_DEPTH_K{1'b0}};
            p1_vld_q <= 1'b0;
            p1_idx_q <= {Q_DEPTH_K{1'b0}};
            fin_q    <= 1'b0;
        end else begin
            rd_idx_q <= rd_idx_d;
            p1_vld_q <= issue_s;
            p1_idx_q <= rd_idx_q;
            fin_q    <= p1_vld_q && (p1_idx_q == LAST_IDX);
        end
    end

    // Synchronous read of the four byte memories, only for indices below N
    always_ff @(posedge Clk) begin
        if (issue_s) begin
            c_rd_q   <= mem_C[rd_idx_q];
            sk_rd_q  <= mem_sk[rd_idx_q];
            k_rd_q   <= mem_k[rd_idx_q];
            rho_rd_q <= mem_rho[rd_idx_q];
        end
    end

    // External byte-memory writes, blocked while BUSY
    always_ff @(posedge Clk) begin
        if (ext_wr_ok_s && wr.wr_en_C)   mem_C[wr.wr_addr_C]     <= wr.wr_di_C;
        if (ext_wr_ok_s && wr.wr_en_sk)  mem_sk[wr.wr_addr_sk]   <= wr.wr_di_sk;
        if (ext_wr_ok_s && wr.wr_en_k)   mem_k[wr.wr_addr_k]     <= wr.wr_di_k;
        if (ext_wr_ok_s && wr.wr_en_rho) mem_rho[wr.wr_addr_rho] <= wr.wr_di_rho;
    end

    // r memory: core writes e during BUSY, external preload otherwise
    always_ff @(posedge Clk) begin
        if (Reset && p1_vld_q) begin
            mem_r[p1_idx_q[Q_DEPTH-1:0]] <= {{(P_WIDTH - P_WIDTH_K){1'b0}}, e_s};
        end else if (ext_wr_ok_s && wr.wr_en_r) begin
            mem_r[wr.wr_addr_r] <= wr.wr_di_r;
        end
    end

    // Lane accumulators and sticky mismatch flag
    always_ff @(posedge Clk) begin
        if (!Reset || start_s || clear_s) begin
            for (int i = 0; i < 8; i++) begin
                lane_r_q[i] <= 32'h0;
                lane_k_q[i] <= 32'h0;
                lane_p_q[i] <= 32'h0;
            end
            mism_q <= 1'b0;
        end else if (p1_vld_q) begin
            lane_r_q[lane_sel_s] <= rotl5(lane_r_q[lane_sel_s]) ^ {24'h0, e_s};
            lane_k_q[lane_sel_s] <= rotl5(lane_k_q[lane_sel_s]) ^ {24'h0, k_rd_q};
            lane_p_q[lane_sel_s] <= rotl5(lane_p_q[lane_sel_s]) ^ {24'h0, rho_rd_q};
            if (e_s != k_rd_q) mism_q <= 1'b1;
        end
    end

    // Output lanes and Valid; session digest falls back to rho lanes on mismatch
    always_ff @(posedge Clk) begin
        if (!Reset || start_s || clear_s) begin
            for (int i = 0; i < 8; i++) begin
                o_r_q[i] <= 32'h0;
                o_k_q[i] <= 32'h0;
            end
            valid_q <= 1'b0;
        end else if (finish_s) begin
            for (int i = 0; i < 8; i++) begin
                o_r_q[i] <= lane_r_q[i];
                o_k_q[i] <= mism_q ? lane_p_q[i] : lane_k_q[i];
            end
            valid_q <= 1'b1;
        end
    end

    assign out_r = o_r_q[out_addr];
    assign out_k = o_k_q[out_addr];
    assign Valid = valid_q;
endmodule

// File: tb/tb_decapsulation.sv
module tb_decapsulation;
    localparam int N = 761;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [1:0]  Cmd;
    logic [2:0]  out_addr;
    logic [31:0] out_r, out_k;
    logic        Valid;

    int total = 0;
    int bad   = 0;

    logic [7:0]  mC   [0:N-1];
    logic [7:0]  msk  [0:N-1];
    logic [7:0]  mk   [0:N-1];
    logic [7:0]  mrho [0:N-1];
    logic [31:0] exp_r [0:7];
    logic [31:0] exp_k [0:7];

    decapsulation_if wr_if ();

    decapsulation dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Cmd      (Cmd),
        .wr       (wr_if),
        .out_addr (out_addr),
        .out_r    (out_r),
        .out_k    (out_k),
        .Valid    (Valid)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        assert (got === expv) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, expv);
        end
    endtask

    task automatic wr_idle();
        wr_if.wr_en_C = 1'b0; wr_if.wr_en_sk = 1'b0; wr_if.wr_en_k = 1'b0;
        wr_if.wr_en_rho = 1'b0; wr_if.wr_en_r = 1'b0;
    endtask

    task automatic clear_arrays();
        for (int i = 0; i < N; i++) begin
            mC[i] = 8'h00; msk[i] = 8'h00; mk[i] = 8'h00; mrho[i] = 8'h00;
        end
    endtask

    // Loads all four byte memories in parallel and seeds mem_r with a marker
    task automatic load_all();
        for (int i = 0; i < N; i++) begin
            wr_if.wr_en_C = 1'b1;   wr_if.wr_addr_C = 11'(i);   wr_if.wr_di_C = mC[i];
            wr_if.wr_en_sk = 1'b1;  wr_if.wr_addr_sk = 11'(i);  wr_if.wr_di_sk = msk[i];
            wr_if.wr_en_k = 1'b1;   wr_if.wr_addr_k = 11'(i);   wr_if.wr_di_k = mk[i];
            wr_if.wr_en_rho = 1'b1; wr_if.wr_addr_rho = 11'(i); wr_if.wr_di_rho = mrho[i];
            wr_if.wr_en_r = 1'b1;   wr_if.wr_addr_r = 10'(i);   wr_if.wr_di_r = 16'h5A5A;
            step();
        end
        wr_idle();
        wr_if.wr_en_r = 1'b1; wr_if.wr_addr_r = 10'(N); wr_if.wr_di_r = 16'hABCD;
        step();
        wr_idle();
    endtask

    // Reference: each lane is a rotate-left-5 then xor accumulator over its share of indices
    task automatic model();
        logic [31:0] R [0:7];
        logic [31:0] K [0:7];
        logic [31:0] P [0:7];
        logic [7:0]  e;
        bit          mism;
        int          j;
        mism = 1'b0;
        for (int i = 0; i < 8; i++) begin R[i] = 32'h0; K[i] = 32'h0; P[i] = 32'h0; end
        for (int n = 0; n < N; n++) begin
            e = mC[n] ^ msk[n];
            j = n % 8;
            R[j] = ((R[j] << 5) | (R[j] >> 27)) ^ 32'(e);
            K[j] = ((K[j] << 5) | (K[j] >> 27)) ^ 32'(mk[n]);
            P[j] = ((P[j] << 5) | (P[j] >> 27)) ^ 32'(mrho[n]);
            if (e != mk[n]) mism = 1'b1;
        end
        for (int i = 0; i < 8; i++) begin
            exp_r[i] = R[i];
            exp_k[i] = mism ? P[i] : K[i];
        end
    endtask

    // Starts the core and waits for Valid; optionally disturbs it with commands and writes
    task automatic run(input string tag, input bit disturb);
        int waited;
        Cmd = 2'd3;
        step();
        Cmd = 2'd0;
        waited = 0;
        while (!Valid && waited < N + 3) begin
            if (disturb && waited >= 10 && waited < 20) begin
                Cmd = 2'd3;
                wr_if.wr_en_C = 1'b1;   wr_if.wr_addr_C = 11'($urandom_range(0, N - 1));   wr_if.wr_di_C = 8'($urandom);
                wr_if.wr_en_sk = 1'b1;  wr_if.wr_addr_sk = 11'($urandom_range(0, N - 1));  wr_if.wr_di_sk = 8'($urandom);
                wr_if.wr_en_k = 1'b1;   wr_if.wr_addr_k = 11'($urandom_range(0, N - 1));   wr_if.wr_di_k = 8'($urandom);
                wr_if.wr_en_rho = 1'b1; wr_if.wr_addr_rho = 11'($urandom_range(0, N - 1)); wr_if.wr_di_rho = 8'($urandom);
                wr_if.wr_en_r = 1'b1;   wr_if.wr_addr_r = 10'($urandom_range(0, N - 1));   wr_if.wr_di_r = 16'($urandom);
            end else begin
                Cmd = 2'd0;
                wr_idle();
            end
            step();
            waited++;
        end
        Cmd = 2'd0;
        wr_idle();
        chk({tag, "_valid"}, 32'(Valid), 32'd1);
    endtask

    task automatic check_out(input string tag);
        for (int a = 0; a < 8; a++) begin
            out_addr = 3'(a);
            #1;
            chk($sformatf("%s_r%0d", tag, a), out_r, exp_r[a]);
            chk($sformatf("%s_k%0d", tag, a), out_k, exp_k[a]);
        end
    endtask

    task automatic check_zero(input string tag);
        for (int a = 0; a < 8; a++) begin
            out_addr = 3'(a);
            #1;
            chk($sformatf("%s_r%0d", tag, a), out_r, 32'h0);
            chk($sformatf("%s_k%0d", tag, a), out_k, 32'h0);
        end
    endtask

    task automatic check_memr(input string tag);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s_memr%0d", tag, i), 32'(dut.mem_r[i]), 32'({8'h00, mC[i] ^ msk[i]}));
        end
        chk({tag, "_memr_beyond"}, 32'(dut.mem_r[N]), 32'h0000ABCD);
    endtask

    initial begin
        int idx;
        bit seen;
        Reset = 1'b0;
        Cmd = 2'd0;
        out_addr = 3'd0;
        wr_idle();
        wr_if.wr_addr_C = 11'd0; wr_if.wr_di_C = 8'd0;
        wr_if.wr_addr_sk = 11'd0; wr_if.wr_di_sk = 8'd0;
        wr_if.wr_addr_k = 11'd0; wr_if.wr_di_k = 8'd0;
        wr_if.wr_addr_rho = 11'd0; wr_if.wr_di_rho = 8'd0;
        wr_if.wr_addr_r = 10'd0; wr_if.wr_di_r = 16'd0;

        // Reset state
        step();
        step();
        chk("rst_valid", 32'(Valid), 32'd0);
        check_zero("rst");
        Reset = 1'b1;
        step();

        // All-zero memories
        clear_arrays();
        load_all();
        model();
        run("zero", 1'b0);
        check_out("zero");
        check_memr("zero");

        // Single matching byte in lane 0
        clear_arrays();
        mC[0] = 8'h01; mk[0] = 8'h01;
        load_all();
        model();
        run("c0", 1'b0);
        check_out("c0");
        out_addr = 3'd0; #1;
        chk("c0_lit_r0", out_r, 32'h08000000);
        chk("c0_lit_k0", out_k, 32'h08000000);

        // Mismatch selects rho lanes
        clear_arrays();
        msk[5] = 8'hFF; mrho[0] = 8'h01;
        load_all();
        model();
        run("mm", 1'b0);
        check_out("mm");
        out_addr = 3'd5; #1;
        chk("mm_lit_r5", out_r, 32'h3FC00000);
        out_addr = 3'd0; #1;
        chk("mm_lit_k0", out_k, 32'h08000000);
        chk("mm_memr5", 32'(dut.mem_r[5]), 32'h000000FF);

        // Random data, k consistent with e (no mismatch)
        for (int i = 0; i < N; i++) begin
            mC[i] = 8'($urandom); msk[i] = 8'($urandom);
            mk[i] = mC[i] ^ msk[i]; mrho[i] = 8'($urandom);
        end
        load_all();
        model();
        run("rnd_ok", 1'b0);
        check_out("rnd_ok");
        check_memr("rnd_ok");

        // Random data with one mismatch, disturbed by Cmd=3 and writes during BUSY
        for (int i = 0; i < N; i++) begin
            mC[i] = 8'($urandom); msk[i] = 8'($urandom);
            mk[i] = mC[i] ^ msk[i]; mrho[i] = 8'($urandom);
        end
        idx = $urandom_range(0, N - 1);
        mk[idx] = mk[idx] ^ 8'h5A;
        load_all();
        model();
        run("rnd_dist", 1'b1);
        check_out("rnd_dist");
        check_memr("rnd_dist");

        // Mismatch only at the final index
        for (int i = 0; i < N; i++) mk[i] = mC[i] ^ msk[i];
        mk[N - 1] = mk[N - 1] ^ 8'h01;
        load_all();
        model();
        run("last_mm", 1'b0);
        check_out("last_mm");

        // Reserved command is a no-op in DONE
        Cmd = 2'd2;
        step();
        Cmd = 2'd0;
        chk("cmd2_valid", 32'(Valid), 32'd1);
        check_out("cmd2");

        // Clear from DONE
        Cmd = 2'd1;
        step();
        Cmd = 2'd0;
        chk("clr_valid", 32'(Valid), 32'd0);
        check_zero("clr");

        // Reset in the middle of BUSY
        Cmd = 2'd3;
        step();
        Cmd = 2'd0;
        for (int i = 0; i < 100; i++) step();
        Reset = 1'b0;
        step();
        Reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < N + 10; i++) begin
            step();
            if (Valid) seen = 1'b1;
        end
        chk("rstbusy_valid", 32'(seen), 32'd0);
        check_zero("rstbusy");

        // Core recovers and computes correctly after the abort
        run("rerun", 1'b0);
        check_out("rerun");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/decapsulation.md
DECAPSULATION -- requirements
Module: decapsulation

Interface
REQ-001 SHALL have parameters: N default 761, number of coefficients processed; Q_DEPTH_K default 11, byte-memory address width; P_WIDTH_K default 8, byte width; Q_DEPTH default 10, r-memory address width; P_WIDTH default 16, r-memory word width.
REQ-002 SHALL have ports:
- Clk  in  1  single clock, rising edge.
- Reset  in  1  synchronous, active-low reset.
- Cmd  in  2  command: 0 no-op, 1 clear, 2 reserved (no-op), 3 start.
- wr_en_C / wr_addr_C / wr_di_C  in  1/11/8  ciphertext byte-memory write port.
- wr_en_sk / wr_addr_sk / wr_di_sk  in  1/11/8  secret-key byte-memory write port.
- wr_en_k / wr_addr_k / wr_di_k  in  1/11/8  confirmation byte-memory write port.
- wr_en_rho / wr_addr_rho / wr_di_rho  in  1/11/8  rejection-value byte-memory write port.
- wr_en_r / wr_addr_r / wr_di_r  in  1/10/16  r-memory preload port.
- out_addr  in  3  lane select.
- out_r  out  32  r-digest lane out_addr.
- out_k  out  32  session-digest lane out_addr.
- Valid  out  1  result ready.
REQ-003 SHALL contain internal memories: mem_C, mem_sk, mem_k, mem_rho, each 2048x8; mem_r, 1024x16; synchronous write, 1-cycle synchronous read.

Function
REQ-004 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-005 External write ports SHALL write on the rising edge when wr_en=1, and only in IDLE or DONE; they SHALL be ignored in BUSY.
REQ-006 Cmd=3 in IDLE or DONE SHALL clear all lanes, the mismatch flag and Valid, then enter BUSY; Cmd is ignored in BUSY.
REQ-007 Cmd=1 in IDLE or DONE SHALL zero all lane registers and the mismatch flag, drop Valid and enter IDLE; memories are unchanged.
REQ-008 BUSY SHALL process index n=0..N-1, one per cycle, pipelined: e = C[n] XOR sk[n]; mem_r[n] <= {8'h00, e}.
REQ-009 Mismatch flag SHALL set if e != k[n] for any n (sticky).
REQ-010 Lane update for byte stream b at index n SHALL be: j = n[2:0]; L[j] <= rotl5(L[j]) XOR {24'h0, b}, where rotl5 is a 32-bit left rotate by 5.
REQ-011 SHALL keep three lane sets of 8x32 bits: R over e, K over k[n], P over rho[n].
REQ-012 On completion: out lanes SHALL be O_r = R and O_k = (mismatch ? P : K), latched in 8x32 output registers, then FSM enters DONE with Valid=1.
REQ-013 Valid SHALL rise no later than N+3 cycles after the start cycle and SHALL hold until Cmd=1, Cmd=3 or reset.
REQ-014 out_r = O_r[out_addr] and out_k = O_k[out_addr], combinational, in every state.
REQ-015 Per-lane element count: lane 0 gets ceil(N/8) elements, others floor or ceil per n mod 8; for N=761, lane 0 gets 96 and lanes 1-7 get 95.
REQ-016 Indices at or above N SHALL never be read or written by the core.

Reset
REQ-017 Reset=0 at a rising edge SHALL force IDLE, Valid=0, all lane, output and mismatch registers to 0, overriding Cmd and any operation in progress; memory contents are not cleared.

Verification
REQ-018 Reset low 2 cycles -> Valid=0; out_r=out_k=32'h0 for all out_addr 0..7.
REQ-019 All memories zero, Cmd=3 -> Valid within 764 cycles; all out_r and out_k lanes = 32'h0; mem_r[0..760] = 16'h0000.
REQ-020 C[0]=8'h01, k[0]=8'h01, rest zero, start -> out_r lane0 = out_k lane0 = 32'h08000000; lanes 1-7 = 0.
REQ-021 sk[5]=8'hFF, rho[0]=8'h01, rest zero, start -> mismatch; out_r lane5 = 32'h3FC00000; out_k lane0 = 32'h08000000, other out_k lanes 0; mem_r[5]=16'h00FF.
REQ-022 Cmd=3 and external writes issued during BUSY -> ignored; results identical to the undisturbed run.
REQ-023 After DONE, Cmd=1 -> Valid=0 next cycle, all outputs 0; Reset=0 mid-BUSY -> IDLE, Valid stays 0.
